// File: rtl/ula_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ULA controller: FSM states, instruction
// fields and the 3-bit ULAControl codes also consumed by the ULA itself.
package ula_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

endpackage

// File: rtl/ula_multicycle_ctrl_funct_decoder.sv
// Combinational ULA operation decoder: forced add/sub, or the R-type funct
// field mapped to a ULAControl code with an unsupported-funct flag.
module ula_funct_decoder
  import ula_multicycle_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ULAControl,
  output logic       FunctIllegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ULAControl   = ULA_ADD;
    FunctIllegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ULAControl = ULA_ADD;
      ALUOP_SUB: ULAControl = ULA_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:  ULAControl = ULA_ADD;
          FN_SUB:  ULAControl = ULA_SUB;
          FN_AND:  ULAControl = ULA_AND;
          FN_OR:   ULAControl = ULA_OR;
          FN_SLT:  ULAControl = ULA_SLT;
          default: FunctIllegal = 1'b1;
        endcase
      end
      default: ULAControl = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/ula_multicycle_ctrl.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback and
// drives the datapath selects, enables and ULAControl for the 8-bit ULA.
module ula_multicycle_ctrl
  import ula_multicycle_ctrl_pkg::*;
#(
  parameter int         OPW         = 6,
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode,
  input  logic [OPW-1:0] Funct,
  input  logic           FlagZ,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ULASrcA,
  output logic [1:0]     ULASrcB,
  output logic [2:0]     ULAControl,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           Illegal
);

  state_t     r_state;
  logic [1:0] w_alu_op;
  logic [2:0] w_dec_ctrl;
  logic       w_funct_illegal;
  logic       w_op_illegal;
  logic       w_mem_write, w_ir_write, w_reg_write, w_illegal;
  logic       w_pc_write, w_branch, w_ula_active;

  always_comb begin
    case (Opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_illegal = 1'b0;
      default:                                       w_op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (r_state)
      S_EXECUTE: w_alu_op = ALUOP_FUNCT;
      S_BRANCH:  w_alu_op = ALUOP_SUB;
      default:   w_alu_op = ALUOP_ADD;
    endcase
  end

  ula_funct_decoder u_funct_decoder (
    .ALUOp        (w_alu_op),
    .Funct        (Funct),
    .ULAControl   (w_dec_ctrl),
    .FunctIllegal (w_funct_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
    if (reset) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEXEC;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    r_state <= S_MEMWB;
        S_EXECUTE:  r_state <= w_funct_illegal ? S_FETCH : S_ALUWB;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the current state; FlagZ only matters through w_branch.
  always_comb begin
    IorD         = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    w_reg_write  = 1'b0;
    ULASrcA      = 1'b0;
    ULASrcB      = 2'b00;
    PCSrc        = 2'b00;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_ula_active = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1; ULASrcB = 2'b01; w_ula_active = 1'b1; w_pc_write = 1'b1;
      end
      S_DECODE: begin
        ULASrcB = 2'b11; w_ula_active = 1'b1; w_illegal = w_op_illegal;
      end
      S_MEMADR:   begin ULASrcA = 1'b1; ULASrcB = 2'b10; w_ula_active = 1'b1; end
      S_MEMRD:    IorD = 1'b1;
      S_MEMWB:    begin w_reg_write = 1'b1; MemtoReg = 1'b1; end
      S_MEMWR:    begin IorD = 1'b1; w_mem_write = 1'b1; end
      S_EXECUTE:  begin ULASrcA = 1'b1; w_ula_active = 1'b1; w_illegal = w_funct_illegal; end
      S_ALUWB:    begin w_reg_write = 1'b1; RegDst = 1'b1; end
      S_BRANCH:   begin ULASrcA = 1'b1; w_ula_active = 1'b1; PCSrc = 2'b01; w_branch = 1'b1; end
      S_ADDIEXEC: begin ULASrcA = 1'b1; ULASrcB = 2'b10; w_ula_active = 1'b1; end
      S_ADDIWB:   w_reg_write = 1'b1;
      S_JUMP:     begin PCSrc = 2'b10; w_pc_write = 1'b1; end
      default: ;
    endcase
  end

  assign ULAControl = w_ula_active ? w_dec_ctrl : ULA_AND;

  // Write enables are held off for the whole reset pulse, independent of the clock.
  assign MemWrite = w_mem_write & ~reset;
  assign IRWrite  = w_ir_write  & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign Illegal  = w_illegal   & ~reset;
  assign PCEn     = (w_pc_write | (w_branch & FlagZ)) & ~reset;

endmodule

// File: tb/tb_ula_multicycle_ctrl.sv
// Self-checking bench for ula_multicycle_ctrl: directed and random instruction
// streams compared cycle by cycle against a per-instruction step model.
module tb_ula_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       FlagZ;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA;
  logic [1:0] ULASrcB, PCSrc;
  logic [2:0] ULAControl;
  logic       PCEn, Illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
    logic [1:0] src_b;
    logic [2:0] ctrl;
    logic [1:0] pc_src;
    logic       pc_en, illegal;
  } outs_t;

  string steps[$];

  always #5 clk = ~clk;

  ula_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Opcode     (Opcode),
    .Funct      (Funct),
    .FlagZ      (FlagZ),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ULASrcA    (ULASrcA),
    .ULASrcB    (ULASrcB),
    .ULAControl (ULAControl),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .Illegal    (Illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic outs_t observed();
    return '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA,
             ULASrcB, ULAControl, PCSrc, PCEn, Illegal};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // R-type funct table; unknown functs add but raise Illegal.
  function automatic logic [3:0] funct_ref(input logic [5:0] f);
    if (f == 6'b100000) return {1'b0, 3'b010};
    if (f == 6'b100010) return {1'b0, 3'b110};
    if (f == 6'b100100) return {1'b0, 3'b000};
    if (f == 6'b100101) return {1'b0, 3'b001};
    if (f == 6'b101010) return {1'b0, 3'b111};
    return {1'b1, 3'b010};
  endfunction

  function automatic outs_t expected(input string step, input logic [5:0] f, input logic z);
    outs_t      o;
    logic [3:0] fr;
    o  = '0;
    fr = funct_ref(f);
    if (step == "FETCH") begin
      o.ir_write = 1; o.src_b = 2'b01; o.ctrl = 3'b010; o.pc_en = 1;
    end else if (step == "DECODE" || step == "DECODE_ILL") begin
      o.src_b = 2'b11; o.ctrl = 3'b010; o.illegal = (step == "DECODE_ILL");
    end else if (step == "MEMADR" || step == "ADDIEXEC") begin
      o.src_a = 1; o.src_b = 2'b10; o.ctrl = 3'b010;
    end else if (step == "MEMRD") begin
      o.iord = 1;
    end else if (step == "MEMWB") begin
      o.reg_write = 1; o.mem_to_reg = 1;
    end else if (step == "MEMWR") begin
      o.iord = 1; o.mem_write = 1;
    end else if (step == "EXECUTE") begin
      o.src_a = 1; o.ctrl = fr[2:0]; o.illegal = fr[3];
    end else if (step == "ALUWB") begin
      o.reg_write = 1; o.reg_dst = 1;
    end else if (step == "BRANCH") begin
      o.src_a = 1; o.ctrl = 3'b110; o.pc_src = 2'b01; o.pc_en = z;
    end else if (step == "ADDIWB") begin
      o.reg_write = 1;
    end else if (step == "JUMP") begin
      o.pc_src = 2'b10; o.pc_en = 1;
    end
    return o;
  endfunction

  function automatic outs_t reset_vec();
    outs_t o;
    o = expected("FETCH", 6'd0, 1'b0);
    o.ir_write = 0;
    o.pc_en    = 0;
    return o;
  endfunction

  function void plan(input logic [5:0] op, input logic [5:0] f);
    steps = {"FETCH"};
    case (op)
      6'b100011: steps = {steps, "DECODE", "MEMADR", "MEMRD", "MEMWB"};
      6'b101011: steps = {steps, "DECODE", "MEMADR", "MEMWR"};
      6'b000000: begin
        steps = {steps, "DECODE", "EXECUTE"};
        if (funct_ref(f) < 4'd8) steps.push_back("ALUWB");
      end
      6'b000100: steps = {steps, "DECODE", "BRANCH"};
      6'b001000: steps = {steps, "DECODE", "ADDIEXEC", "ADDIWB"};
      6'b000010: steps = {steps, "DECODE", "JUMP"};
      default:   steps.push_back("DECODE_ILL");
    endcase
  endfunction

  // Entered and left at a falling edge; abort_at > 0 fires reset in that cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] f,
                           input logic branch_z, input int abort_at);
    Opcode = op;
    Funct  = f;
    plan(op, f);
    foreach (steps[i]) begin
      FlagZ = (steps[i] == "BRANCH") ? branch_z : 1'($urandom_range(0, 1));
      #1;
      check($sformatf("%s c%0d %s", tag, i + 1, steps[i]), observed(), expected(steps[i], f, FlagZ));
      if (i + 1 == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check({tag, " async RegWrite"}, 32'(RegWrite), 32'd0);
        check({tag, " async outs"}, observed(), reset_vec());
        @(posedge clk);
        @(negedge clk);
        check({tag, " held outs"}, observed(), reset_vec());
        reset = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] legal_ops[6];
    logic [5:0] legal_fn[5];
    logic [5:0] op, fn;
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    legal_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset  = 1'b1;
    FlagZ  = 1'b0;
    Opcode = 6'b100011;
    Funct  = 6'b000000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      FlagZ = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("reset c%0d", c), observed(), reset_vec());
    end
    reset = 1'b0;

    run_instr("lw", 6'b100011, 6'h00, 1'b0, 0);
    run_instr("sub", 6'b000000, 6'b100010, 1'b0, 0);
    run_instr("add", 6'b000000, 6'b100000, 1'b0, 0);
    run_instr("and", 6'b000000, 6'b100100, 1'b0, 0);
    run_instr("or", 6'b000000, 6'b100101, 1'b0, 0);
    run_instr("slt", 6'b000000, 6'b101010, 1'b0, 0);
    run_instr("beq_z1", 6'b000100, 6'h15, 1'b1, 0);
    run_instr("beq_z0", 6'b000100, 6'h2a, 1'b0, 0);
    run_instr("sw", 6'b101011, 6'h00, 1'b0, 0);
    run_instr("j", 6'b000010, 6'h00, 1'b0, 0);
    run_instr("addi", 6'b001000, 6'h3f, 1'b0, 0);
    run_instr("bad_op", 6'b111111, 6'h00, 1'b0, 0);
    run_instr("bad_fn", 6'b000000, 6'b000000, 1'b0, 0);
    run_instr("lw_abort", 6'b100011, 6'h00, 1'b0, 5);
    run_instr("after_abort", 6'b001000, 6'h00, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      int pick;
      pick = int'($urandom_range(0, 6));
      if (pick == 6) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[pick];
      end
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else                           fn = legal_fn[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d op%02h fn%02h", n, op, fn), op, fn,
                1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_multicycle_ctrl.md
Name: ula_multicycle_ctrl

Overview:
- Multicycle control unit that drives the 8-bit ULA.
- Decodes Opcode/Funct from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Issues the 3-bit ULAControl code to the ULA and consumes its FlagZ for branch resolution.
- Sits between the instruction register and the datapath muxes and enables.

Parameters:
- OPW, 6, opcode and funct field width.
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  instruction bits [31:26].
- Funct  in  6  instruction bits [5:0].
- FlagZ  in  1  ULA zero flag from the current cycle's ULAResult.
- IorD  out  1  memory address select: 0 = PC, 1 = ULAOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback select: 0 = ULAOut, 1 = Data.
- RegWrite  out  1  register file write enable.
- ULASrcA  out  1  0 = PC, 1 = register A.
- ULASrcB  out  2  00 = B, 01 = const 1, 10 = SignImm, 11 = SignImm<<1.
- ULAControl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- PCSrc  out  2  00 = ULAResult, 01 = ULAOut, 10 = jump target.
- PCEn  out  1  PC load = PCWrite | (Branch & FlagZ).
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

Behaviour:
- Moore FSM with 4-bit state register, clocked on posedge clk, async reset to FETCH.
- While reset = 1: MemWrite, IRWrite, RegWrite, PCEn and Illegal are forced 0; all other outputs take their FETCH values.
- Reset mid-instruction aborts the instruction; no partial write occurs after reset deasserts.
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- State transitions and outputs (signals not listed are 0):
  - FETCH: IRWrite=1, ULASrcB=01, ULAControl=010, PCSrc=00, PCWrite=1. Next state: DECODE.
  - DECODE: ULASrcB=11, ULAControl=010 (branch target into ULAOut). Next state by opcode:
    - LW or SW: MEMADR
    - RTYPE: EXECUTE
    - BEQ: BRANCH
    - ADDI: ADDIEXEC
    - J: JUMP
    - anything else: FETCH, with Illegal=1 for one cycle.
  - MEMADR: ULASrcA=1, ULASrcB=10, ULAControl=010. Next state: MEMRD for LW, MEMWR for SW.
  - MEMRD: IorD=1. Next state: MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next state: FETCH.
  - EXECUTE: ULASrcA=1, ULASrcB=00, ULAControl from the funct decoder. Next state: ALUWB.
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
  - BRANCH: ULASrcA=1, ULASrcB=00, ULAControl=110, PCSrc=01, Branch=1, so PCEn=FlagZ combinationally in this cycle. Next state: FETCH.
  - ADDIEXEC: ULASrcA=1, ULASrcB=10, ULAControl=010. Next state: ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0. Next state: FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next state: FETCH.
- Funct decode (EXECUTE only):
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other -> 010, with Illegal=1 in EXECUTE and ALUWB suppressed: next state FETCH, RegWrite stays 0.
- Unused state encodings go to FETCH on the next clock with all enables 0.
- Latencies: LW 5 cycles; SW, R-type and ADDI 4 cycles; BEQ and J 3 cycles.
- FlagZ is sampled only in BRANCH and ignored in every other state.

Decomposition:
- Shared package holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - opcode and funct constants
  - ULAControl codes (ULA_AND=000, ULA_OR=001, ULA_ADD=010, ULA_SUB=110, ULA_SLT=111), which the ULA also uses.
- One natural sub-module: ula_funct_decoder. It is combinational: ALUOp[1:0] + Funct in, ULAControl + FunctIllegal out. ALUOp encoding: 00 = add, 01 = sub, 10 = use funct.

Test Plan:
- Reset held 3 cycles, then released with Opcode=100011 (LW): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5; PCEn=1 only in cycle 1.
- R-type with Funct=100010: EXECUTE shows ULASrcA=1, ULASrcB=00, ULAControl=110. ALUWB shows RegWrite=1, RegDst=1. Total 4 cycles. Repeat for Funct 100000/100100/100101/101010 -> 010/000/001/111.
- BEQ with FlagZ=1 in BRANCH: PCEn=1, PCSrc=01, ULAControl=110. Same with FlagZ=0: PCEn=0. FlagZ toggled in other states has no effect.
- SW then J back-to-back: MemWrite=1 with IorD=1 only in cycle 4 of SW. J gives PCSrc=10 and PCEn=1 in its cycle 3. Neither instruction asserts RegWrite.
- Opcode=111111: Illegal=1 for exactly one cycle in DECODE, return to FETCH. Funct=000000 with RTYPE: Illegal=1 in EXECUTE, no RegWrite.
- Reset asserted asynchronously mid-MEMWB: RegWrite drops immediately without waiting for a clock edge. After release, state is FETCH and IRWrite=1.
